// File: rtl/cbus_rr_arbiter_pkg.sv
// Common cache-line bus (cbus) types shared by the front-ends, the arbiter
// and the top-level cbus port.
package cbus_rr_arbiter_pkg;

  localparam int CBUS_AW = 32;
  localparam int CBUS_DW = 32;
  localparam int CBUS_LW = 4;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_policy_t;

  // len is beats-1: a single-beat transaction carries len = 0.
  typedef struct packed {
    logic                   valid;
    logic                   write;
    logic [CBUS_AW-1:0]     addr;
    logic [CBUS_LW-1:0]     len;
    logic [CBUS_DW-1:0]     data;
    logic [CBUS_DW/8-1:0]   strb;
  } cbus_req_t;

  typedef struct packed {
    logic               ready;
    logic               last;
    logic [CBUS_DW-1:0] data;
  } cbus_resp_t;

  // Increment an index modulo n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cbus_arb_select.sv
// Combinational rotate-priority picker. Scans the valid vector starting at
// rr_ptr (round-robin) or at 0 (fixed priority) and returns the first hit.
module cbus_arb_select
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int          NUM_INPUTS = 4,
  parameter arb_policy_t POLICY     = ARB_RR,
  localparam int         IW         = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic [IW-1:0]         rr_ptr,
  output logic [IW-1:0]         winner,
  output logic                  any_valid
);

  logic [IW-1:0] base;
  int            idx;

  assign base = (POLICY == ARB_RR) ? rr_ptr : '0;

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      idx = int'(base) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (valid[idx[IW-1:0]]) begin
        winner    = idx[IW-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Shares the single cbus between NUM_INPUTS requesters. A winner is registered
// in IDLE, then owns the bus until the response beat flagged last completes.
// Requests and responses of the owner pass through combinationally so
// per-beat write data and strobes track the owner live.
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int          NUM_INPUTS = 4,
  parameter arb_policy_t POLICY     = ARB_RR,
  localparam int         IW         = $clog2(NUM_INPUTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp,
  output logic [IW-1:0]                grant_idx,
  output logic                         busy,
  output logic                         txn_done
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic                  state_q, state_d;
  logic [IW-1:0]         grant_idx_q, grant_idx_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_INPUTS-1:0] req_valid;
  logic [IW-1:0]         sel_winner;
  logic                  sel_any;
  logic                  fin;

  // Gather the valid bits for the picker.
  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) req_valid[i] = ireqs[i].valid;
  end

  cbus_arb_select #(
    .NUM_INPUTS(NUM_INPUTS),
    .POLICY    (POLICY)
  ) u_select (
    .valid    (req_valid),
    .rr_ptr   (rr_ptr_q),
    .winner   (sel_winner),
    .any_valid(sel_any)
  );

  assign busy      = (state_q == ST_BUSY);
  assign fin       = busy & oresp.ready & oresp.last;
  assign txn_done  = fin;
  assign grant_idx = grant_idx_q;

  // Grant in IDLE, release on the final beat; the grant is never revoked.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          grant_idx_d = sel_winner;
          state_d     = ST_BUSY;
        end
      end
      default: begin
        if (fin) begin
          state_d = ST_IDLE;
          if (POLICY == ARB_RR)
            rr_ptr_d = IW'(wrap_inc(int'(grant_idx_q), NUM_INPUTS));
        end
      end
    endcase
  end

  // Route the owner's request out and the memory response back to the owner.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (busy) begin
      oreq                = ireqs[grant_idx_q];
      iresps[grant_idx_q] = oresp;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: one round-robin and one fixed-priority instance,
// each compared every cycle against a transaction-level reference model.
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cbus_req_t  [N-1:0] ireqs  [2];
  cbus_resp_t [N-1:0] iresps [2];
  cbus_req_t          oreq   [2];
  cbus_resp_t         oresp  [2];
  logic [IW-1:0]      gidx   [2];
  logic               busy   [2];
  logic               done   [2];

  cbus_rr_arbiter #(.NUM_INPUTS(N), .POLICY(ARB_RR)) dut_rr (
    .clk(clk), .reset(rst), .ireqs(ireqs[0]), .iresps(iresps[0]),
    .oreq(oreq[0]), .oresp(oresp[0]), .grant_idx(gidx[0]),
    .busy(busy[0]), .txn_done(done[0]));

  cbus_rr_arbiter #(.NUM_INPUTS(N), .POLICY(ARB_FIXED)) dut_fx (
    .clk(clk), .reset(rst), .ireqs(ireqs[1]), .iresps(iresps[1]),
    .oreq(oreq[1]), .oresp(oresp[1]), .grant_idx(gidx[1]),
    .busy(busy[1]), .txn_done(done[1]));

  int n_chk = 0, n_pass = 0;
  int viol_idle [2] = '{0, 0};
  int viol_drop [2] = '{0, 0};

  // reference model: d = 0 is round-robin, d = 1 is fixed priority
  int m_busy [2], m_own [2], m_ptr [2], m_beat [2];
  bit last_done [2];
  int last_own  [2];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // protocol monitors: ready while idle, owner dropping valid
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && oresp[d].ready && !busy[d]) viol_idle[d]++;
      if (!rst && busy[d] && !ireqs[d][gidx[d]].valid) viol_drop[d]++;
    end
  end

  function automatic int pick(input int d);
    int base;
    base = (d == 0) ? m_ptr[d] : 0;
    for (int k = 0; k < N; k++)
      if (ireqs[d][(base + k) % N].valid) return (base + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_own[d] = 0; m_ptr[d] = 0; m_beat[d] = 0;
      last_done[d] = 0; last_own[d] = 0;
    end
  endtask

  // Compare both DUTs against the model for the current inputs, then clock.
  task automatic cyc();
    cbus_req_t          er;
    cbus_resp_t [N-1:0] ersp;
    bit                 edone;
    int nb [2], no [2], np [2], nbt [2];
    int p;
    #1;
    for (int d = 0; d < 2; d++) begin
      er   = m_busy[d] ? ireqs[d][m_own[d]] : '0;
      ersp = '0;
      if (m_busy[d]) ersp[m_own[d]] = oresp[d];
      edone = m_busy[d] && oresp[d].ready && oresp[d].last;
      chk($sformatf("oreq%0d", d), oreq[d], er);
      chk($sformatf("iresps%0d", d), iresps[d], ersp);
      chk($sformatf("busy%0d", d), busy[d], m_busy[d]);
      chk($sformatf("done%0d", d), done[d], edone);
      if (m_busy[d]) chk($sformatf("gidx%0d", d), gidx[d], m_own[d]);
      nb[d] = m_busy[d]; no[d] = m_own[d]; np[d] = m_ptr[d]; nbt[d] = m_beat[d];
      last_done[d] = edone; last_own[d] = m_own[d];
      if (!m_busy[d]) begin
        p = pick(d);
        if (p >= 0) begin nb[d] = 1; no[d] = p; nbt[d] = 0; end
      end else if (oresp[d].ready) begin
        if (edone) begin
          nb[d] = 0; nbt[d] = 0;
          if (d == 0) np[d] = (m_own[d] + 1) % N;
        end else nbt[d]++;
      end
    end
    chk("rr_ptr", dut_rr.rr_ptr_q, m_ptr[0]);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = nb[d]; m_own[d] = no[d]; m_ptr[d] = np[d]; m_beat[d] = nbt[d];
    end
    if (rst) model_reset();
  endtask

  task automatic setreq(input int d, input int i, input int len, input logic [31:0] data);
    ireqs[d][i].valid = 1'b1;
    ireqs[d][i].write = 1'b0;
    ireqs[d][i].addr  = 32'h1000 * (i + 1);
    ireqs[d][i].len   = CBUS_LW'(len);
    ireqs[d][i].data  = data;
    ireqs[d][i].strb  = 4'hf;
  endtask

  task automatic resp(input int d, input bit rdy, input bit lst);
    oresp[d].ready = rdy;
    oresp[d].last  = lst;
    oresp[d].data  = $urandom;
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin ireqs[d] = '0; oresp[d] = '0; end
  endtask

  // Two requesters held valid with single-beat transactions; check grant order.
  task automatic pair_seq(input int d, input int a, input int b, input int e [4]);
    setreq(d, a, 0, $urandom);
    setreq(d, b, 0, $urandom);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("seq%0d_%0d", d, k), gidx[d], e[k]);
      resp(d, 1, 1);
      cyc();
      resp(d, 0, 0);
      chk($sformatf("bubble%0d_%0d", d, k), busy[d], 0);
    end
    ireqs[d] = '0;
  endtask

  task automatic newreq(input int d, input int i);
    setreq(d, i, $urandom_range(3), $urandom);
    ireqs[d][i].write = 1'($urandom_range(1));
    ireqs[d][i].addr  = $urandom;
  endtask

  task automatic drive_rand();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        if (last_done[d] && last_own[d] == i) begin
          if ($urandom_range(1) == 1) newreq(d, i);
          else ireqs[d][i] = '0;
        end else if (!ireqs[d][i].valid && $urandom_range(2) == 0) newreq(d, i);
        if (ireqs[d][i].valid) begin
          ireqs[d][i].data = $urandom;
          ireqs[d][i].strb = 4'($urandom_range(15));
        end
      end
      if (m_busy[d] == 1 && $urandom_range(3) != 0)
        resp(d, 1, m_beat[d] == int'(ireqs[d][m_own[d]].len));
      else oresp[d] = '0;
    end
  endtask

  int v;
  int last_g [N];
  int gap_max;

  initial begin
    rst = 1'b1;
    clr();
    model_reset();
    #2;
    chk("rst_busy", busy[0], 0);
    chk("rst_oreq", oreq[0], '0);
    chk("rst_done", done[0], 0);
    chk("rst_gidx", gidx[0], 0);
    cyc(); cyc();
    rst = 1'b0;

    // only input 2, four beats
    setreq(0, 2, 3, 32'h1111);
    #1 chk("t1_bubble", busy[0], 0);
    cyc();
    chk("t1_busy", busy[0], 1);
    chk("t1_gidx", gidx[0], 2);
    chk("t1_ovalid", oreq[0].valid, 1);
    for (int b = 0; b < 4; b++) begin
      resp(0, 1, b == 3);
      #1;
      chk("t1_rdy2", iresps[0][2].ready, 1);
      chk("t1_others", {iresps[0][0], iresps[0][1], iresps[0][3]}, '0);
      chk("t1_done", done[0], b == 3);
      cyc();
    end
    clr();
    chk("t1_ptr", dut_rr.rr_ptr_q, 3);
    chk("t1_idle", busy[0], 0);

    // per-beat write data tracks the owner
    setreq(0, 0, 1, 32'hA);
    ireqs[0][0].write = 1'b1;
    cyc();
    chk("t4_beat1", oreq[0].data, 32'hA);
    resp(0, 1, 0);
    cyc();
    ireqs[0][0].data = 32'hB;
    resp(0, 1, 1);
    #1;
    chk("t4_beat2", oreq[0].data, 32'hB);
    chk("t4_done", done[0], 1);
    cyc();
    clr();

    // reset during beat 2 of a 4-beat transaction
    setreq(0, 1, 3, 32'h55);
    cyc();
    resp(0, 1, 0);
    cyc();
    resp(0, 1, 0);
    #1 rst = 1'b1;
    #1;
    chk("t5_busy", busy[0], 0);
    chk("t5_oreq", oreq[0], '0);
    chk("t5_done", done[0], 0);
    model_reset();
    cyc();
    rst = 1'b0;
    clr();
    chk("t5_ptr", dut_rr.rr_ptr_q, 0);

    // round-robin alternation from rr_ptr = 0; fixed priority starvation
    pair_seq(0, 0, 3, '{0, 3, 0, 3});
    pair_seq(1, 1, 2, '{1, 1, 1, 1});

    // fairness: all inputs requesting, single beats
    for (int i = 0; i < N; i++) begin setreq(0, i, 0, $urandom); last_g[i] = -1; end
    gap_max = 0;
    for (int k = 0; k < 3 * N; k++) begin
      cyc();
      if (last_g[gidx[0]] >= 0 && k - last_g[gidx[0]] - 1 > gap_max)
        gap_max = k - last_g[gidx[0]] - 1;
      last_g[gidx[0]] = k;
      resp(0, 1, 1);
      cyc();
      resp(0, 0, 0);
    end
    chk("fair_gap", gap_max, N - 1);
    clr();

    // ready while idle is ignored and flagged
    cyc();
    v = viol_idle[0];
    resp(0, 1, 1);
    #1;
    chk("t6_iresps", iresps[0], '0);
    chk("t6_done", done[0], 0);
    cyc();
    resp(0, 0, 0);
    chk("t6_busy", busy[0], 0);
    chk("t6_flag", viol_idle[0], v + 1);

    // randomized traffic against the model
    clr();
    cyc();
    for (int c = 0; c < 1500; c++) begin
      drive_rand();
      cyc();
    end
    chk("no_drop", viol_drop[0] + viol_drop[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
